// File: rtl/root_cal_8.sv
// Integer 8th root: floor(x^(1/8)) as three chained bit-serial floor square roots on one shared engine.
// Optional ROOT_CAL_8_EXACT_CHECK_EN adds o_exact (operand is a perfect 8th power).
module root_cal_8 (
  input  logic         i_clk,
  input  logic         i_reset_n,
  input  logic [127:0] i_in,
  input  logic         i_valid,
  output logic         o_ready,
  output logic [15:0]  o_out,
  output logic         o_valid,
  input  logic         i_ready
`ifdef ROOT_CAL_8_EXACT_CHECK_EN
  ,
  output logic         o_exact
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROOT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [127:0] rad;
  logic [65:0]  rem;
  logic [63:0]  q;
  logic [1:0]   stage;
  logic [5:0]   cnt;

  logic [65:0]  rem_sh, trial, rem_nxt;
  logic [63:0]  q_nxt;
  logic         fit;

`ifdef ROOT_CAL_8_EXACT_CHECK_EN
  logic         exact_acc;
`endif

  // One digit-by-digit sqrt iteration: bring down two radicand bits, try q*4+1.
  always_comb begin
    rem_sh  = (rem << 2) | {64'b0, rad[127:126]};
    trial   = {q, 2'b01};
    fit     = (rem_sh >= trial);
    rem_nxt = fit ? (rem_sh - trial) : rem_sh;
    q_nxt   = (q << 1) | {63'b0, fit};
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) state <= IDLE;
    else            state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_valid) state_nxt = ROOT;
      ROOT:    if ((cnt == 6'd0) && (stage == 2'd2)) state_nxt = DONE;
      DONE:    if (i_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == IDLE);
    o_valid = (state == DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      rad   <= '0;
      rem   <= '0;
      q     <= '0;
      stage <= '0;
      cnt   <= '0;
      o_out <= '0;
`ifdef ROOT_CAL_8_EXACT_CHECK_EN
      exact_acc <= 1'b0;
      o_exact   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (i_valid) begin
            rad   <= i_in;
            rem   <= '0;
            q     <= '0;
            stage <= 2'd0;
            cnt   <= 6'd63;
`ifdef ROOT_CAL_8_EXACT_CHECK_EN
            exact_acc <= 1'b1;
`endif
          end
        end
        ROOT: begin
          if (cnt != 6'd0) begin
            rad <= rad << 2;
            rem <= rem_nxt;
            q   <= q_nxt;
            cnt <= cnt - 6'd1;
          end else begin
            // Stage end: the finished root becomes the left-aligned radicand of the next stage.
            rem <= '0;
            q   <= '0;
`ifdef ROOT_CAL_8_EXACT_CHECK_EN
            if (rem_nxt != '0) exact_acc <= 1'b0;
`endif
            case (stage)
              2'd0: begin
                rad   <= {q_nxt, 64'b0};
                cnt   <= 6'd31;
                stage <= 2'd1;
              end
              2'd1: begin
                rad   <= {q_nxt[31:0], 96'b0};
                cnt   <= 6'd15;
                stage <= 2'd2;
              end
              default: begin
                rad   <= '0;
                o_out <= q_nxt[15:0];
`ifdef ROOT_CAL_8_EXACT_CHECK_EN
                o_exact <= exact_acc && (rem_nxt == '0);
`endif
              end
            endcase
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_root_cal_8.sv
// Scoreboard bench for root_cal_8: expected roots come from an independent binary-search model.
// o_exact is checked only when ROOT_CAL_8_EXACT_CHECK_EN is defined.
module tb_root_cal_8;

  logic         i_clk;
  logic         i_reset_n;
  logic [127:0] i_in;
  logic         i_valid;
  logic         o_ready;
  logic [15:0]  o_out;
  logic         o_valid;
  logic         i_ready;
`ifdef ROOT_CAL_8_EXACT_CHECK_EN
  logic         o_exact;
`endif

  root_cal_8 dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_in      (i_in),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .o_out     (o_out),
    .o_valid   (o_valid),
    .i_ready   (i_ready)
`ifdef ROOT_CAL_8_EXACT_CHECK_EN
    ,
    .o_exact   (o_exact)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct packed {
    logic [15:0] out;
    logic        exact;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [135:0] pow8(input logic [16:0] k);
    logic [135:0] p;
    p = 136'd1;
    for (int unsigned i = 0; i < 8; i++) p = p * {119'b0, k};
    return p;
  endfunction

  function automatic logic [15:0] root8(input logic [127:0] x);
    int unsigned lo, hi, mid;
    lo = 0;
    hi = 65535;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (pow8(mid[16:0]) <= {8'b0, x}) lo = mid;
      else hi = mid - 1;
    end
    return lo[15:0];
  endfunction

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic start_op(input logic [127:0] x);
    exp_t e;
    e.out   = root8(x);
    e.exact = (pow8({1'b0, e.out}) == {8'b0, x});
    checks++;
    if (o_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_ready: o_ready=%b required 1", o_ready);
    end
    sb.push_back(e);
    i_in    = x;
    i_valid = 1'b1;
    tick;
    i_valid = 1'b0;
  endtask

  task automatic wait_result(input string name, output int lat);
    exp_t e;
    lat = 0;
    while (o_valid !== 1'b1 && lat < 300) begin
      tick;
      lat++;
    end
    checks++;
    if (o_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s_timeout: o_valid=%b required 1 within 300 cycles", name, o_valid);
    end else if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s_unexpected: o_out=%0d with empty scoreboard", name, o_out);
    end else begin
      e = sb.pop_front();
      if (o_out !== e.out) begin
        errors++;
        $display("FAIL %s_out: o_out=%0d required %0d", name, o_out, e.out);
      end
`ifdef ROOT_CAL_8_EXACT_CHECK_EN
      checks++;
      if (o_exact !== e.exact) begin
        errors++;
        $display("FAIL %s_exact: o_exact=%b required %b", name, o_exact, e.exact);
      end
`endif
    end
  endtask

  task automatic handoff(input string name);
    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
      errors++;
      $display("FAIL %s_handoff: o_valid=%b o_ready=%b required 0 1", name, o_valid, o_ready);
    end
  endtask

  task automatic run_one(input string name, input logic [127:0] x);
    int lat;
    start_op(x);
    wait_result(name, lat);
    handoff(name);
  endtask

  task automatic test_reset;
    i_reset_n = 1'b0;
    i_in      = '0;
    i_valid   = 1'b0;
    i_ready   = 1'b0;
    repeat (3) tick;
    i_reset_n = 1'b1;
    checks++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0 || o_out !== 16'd0) begin
      errors++;
      $display("FAIL reset: o_ready=%b o_valid=%b o_out=%0d required 1 0 0", o_ready, o_valid, o_out);
    end
  endtask

  task automatic test_zero;
    int lat;
    start_op(128'd0);
    wait_result("zero", lat);
    checks++;
    if (lat != 112) begin
      errors++;
      $display("FAIL latency: cycles=%0d required 112", lat);
    end
    handoff("zero");
  endtask

  task automatic test_values;
    logic [127:0] vals[6];
    logic [127:0] r;
    logic [135:0] p;
    vals[0] = 128'd256;
    vals[1] = 128'd255;
    vals[2] = 128'd6561;
    vals[3] = 128'd6560;
    p = pow8(17'd65535);
    vals[4] = p[127:0];
    vals[5] = '1;
    for (int i = 0; i < 6; i++) run_one($sformatf("table%0d", i), vals[i]);
    for (int i = 0; i < 4; i++) begin
      r = {$urandom, $urandom, $urandom, $urandom};
      run_one($sformatf("rand%0d", i), r);
      p = pow8({1'b0, 16'($urandom_range(2, 65535))});
      run_one($sformatf("pow%0d", i), p[127:0]);
      run_one($sformatf("powm1_%0d", i), p[127:0] - 128'd1);
    end
  endtask

  task automatic test_backpressure;
    int lat;
    start_op(128'd390625);
    wait_result("bp", lat);
    for (int i = 0; i < 10; i++) begin
      tick;
      checks++;
      if (o_valid !== 1'b1 || o_out !== 16'd5 || o_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold%0d: o_valid=%b o_out=%0d o_ready=%b required 1 5 0",
                 i, o_valid, o_out, o_ready);
      end
    end
    handoff("bp");
  endtask

  task automatic test_back_to_back_busy;
    int lat;
    int extra;
    extra = 0;
    start_op(128'd256);
    i_in    = 128'd6561;
    i_valid = 1'b1;
    repeat (50) tick;
    i_valid = 1'b0;
    wait_result("busy", lat);
    checks++;
    if (lat != 62) begin
      errors++;
      $display("FAIL busy_latency: cycles=%0d required 62", lat);
    end
    handoff("busy");
    repeat (130) begin
      tick;
      if (o_valid === 1'b1) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL busy_extra_valid: cycles_valid=%0d required 0", extra);
    end
  endtask

  task automatic test_midop_reset;
    int lat;
    start_op(128'd6561);
    repeat (49) tick;
    i_reset_n = 1'b0;
    tick;
    i_reset_n = 1'b1;
    sb.delete();
    checks++;
    if (o_valid !== 1'b0 || o_ready !== 1'b1 || o_out !== 16'd0) begin
      errors++;
      $display("FAIL midreset: o_valid=%b o_ready=%b o_out=%0d required 0 1 0", o_valid, o_ready, o_out);
    end
    start_op(128'd256);
    wait_result("after_reset", lat);
    checks++;
    if (lat != 112) begin
      errors++;
      $display("FAIL after_reset_latency: cycles=%0d required 112", lat);
    end
    handoff("after_reset");
  endtask

  initial begin
    test_reset;
    test_zero;
    test_values;
    test_backpressure;
    test_back_to_back_busy;
    test_midop_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
